// File: rtl/ifetch_queue_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ifetch_queue_if
// Brief    : Bundle of the fetch unit's memory, redirect and decode-side
//            handshake signals. "master" is the fetch unit, "slave" is the
//            surrounding core / memory environment.
// Revision : 1.0 - initial release
// ============================================================================
interface ifetch_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                    redirect_i;
    logic [DATA_WIDTH-1:0]   redirect_pc_i;
    logic                    imem_req_o;
    logic [DATA_WIDTH-1:0]   imem_addr_o;
    logic                    imem_gnt_i;
    logic                    imem_rvalid_i;
    logic [DATA_WIDTH-1:0]   imem_rdata_i;
    logic                    instr_valid_o;
    logic [DATA_WIDTH-1:0]   instr_o;
    logic [DATA_WIDTH-1:0]   instr_pc_o;
    logic                    instr_ready_i;
    logic [$clog2(DEPTH):0]  fifo_count_o;

    modport master (
        input  redirect_i, redirect_pc_i,
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output instr_valid_o, instr_o, instr_pc_o,
        input  instr_ready_i,
        output fifo_count_o
    );

    modport slave (
        output redirect_i, redirect_pc_i,
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  instr_valid_o, instr_o, instr_pc_o,
        output instr_ready_i,
        input  fifo_count_o
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Brief    : Instruction fetch unit with prefetch FIFO. Issues word-aligned
//            requests, tags responses with their PC, buffers them and hands
//            them to decode. A redirect flushes the buffer and drops any
//            responses still in flight.
//            Optional macro IFQ_BYPASS_EN: a response arriving while the FIFO
//            is empty and decode is ready goes straight to the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    ifetch_queue_if.master bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_sum_w = c_cnt_w + 1;
    localparam int c_out_w = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_tag_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [c_tag_w-1:0]    c_tag_last = c_tag_w'(MAX_OUTSTANDING - 1);
    localparam logic [DATA_WIDTH-1:0] c_pc_step  = DATA_WIDTH'(4);

    // Fetch address and in-flight accounting
    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic [c_out_w-1:0]    r_outstanding;
    logic [c_out_w-1:0]    r_discard;

    // PC tags of granted, not-yet-answered (and not discarded) requests
    logic [DATA_WIDTH-1:0] r_tag_q [MAX_OUTSTANDING];
    logic [c_tag_w-1:0]    r_tag_wr;
    logic [c_tag_w-1:0]    r_tag_rd;

    // Data FIFO holding {instruction, pc}
    logic [DATA_WIDTH-1:0] r_fifo_instr [DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_pc    [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;

    logic                  w_resp;
    logic                  w_resp_keep;
    logic                  w_resp_drop;
    logic [c_sum_w-1:0]    w_reserved;
    logic                  w_req;
    logic                  w_fire;
    logic                  w_head_valid;
    logic                  w_bypass;
    logic                  w_valid;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_tag_head;
    logic                  w_unused_pc_lsbs;

    // A response only counts when something is actually in flight; stray
    // rvalids (e.g. from a memory that outlived our reset) are ignored.
    assign w_resp      = bus.imem_rvalid_i && (r_outstanding != '0);
    assign w_resp_keep = w_resp && (r_discard == '0);
    assign w_resp_drop = w_resp && (r_discard != '0);
    assign w_tag_head  = r_tag_q[r_tag_rd];

    // Every in-flight request owns a FIFO slot, so a returning word always fits.
    assign w_reserved = c_sum_w'(r_count) + c_sum_w'(r_outstanding);
    assign w_req      = rst_n && !bus.redirect_i
                      && (w_reserved < c_sum_w'(DEPTH))
                      && (r_outstanding < c_out_w'(MAX_OUTSTANDING))
                      && (r_discard == '0);
    assign w_fire     = w_req && bus.imem_gnt_i;

    assign w_head_valid = (r_count != '0);

`ifdef IFQ_BYPASS_EN
    assign w_bypass = !w_head_valid && w_resp_keep && !bus.redirect_i && bus.instr_ready_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_valid = !bus.redirect_i && (w_head_valid || w_bypass);
    assign w_pop   = w_valid && bus.instr_ready_i && !w_bypass;
    assign w_push  = w_resp_keep && !bus.redirect_i && !w_bypass;

    // Low address bits of a redirect target are dropped (word alignment).
    assign w_unused_pc_lsbs = ^bus.redirect_pc_i[1:0];

    assign bus.imem_req_o    = w_req;
    assign bus.imem_addr_o   = r_fetch_pc;
    assign bus.instr_valid_o = w_valid;
    assign bus.instr_o       = w_bypass ? bus.imem_rdata_i : r_fifo_instr[r_rd_ptr];
    assign bus.instr_pc_o    = w_bypass ? w_tag_head : r_fifo_pc[r_rd_ptr];
    assign bus.fifo_count_o  = r_count;

    // Fetch PC, outstanding count and discard count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_out_w'(w_fire) - c_out_w'(w_resp);
            if (bus.redirect_i) begin
                r_fetch_pc <= {bus.redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
                // Everything still in flight after this cycle is stale.
                r_discard  <= r_outstanding - c_out_w'(w_resp);
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + c_pc_step;
                end
                if (w_resp_drop) begin
                    r_discard <= r_discard - 1'b1;
                end
            end
        end
    end

    // In-order PC tag queue, pushed on grant and popped on a kept response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_wr <= '0;
            r_tag_rd <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_tag_q[i] <= '0;
            end
        end else if (bus.redirect_i) begin
            r_tag_wr <= '0;
            r_tag_rd <= '0;
        end else begin
            if (w_fire) begin
                r_tag_q[r_tag_wr] <= r_fetch_pc;
                r_tag_wr          <= (r_tag_wr == c_tag_last) ? '0 : r_tag_wr + 1'b1;
            end
            if (w_resp_keep) begin
                r_tag_rd <= (r_tag_rd == c_tag_last) ? '0 : r_tag_rd + 1'b1;
            end
        end
    end

    // Data FIFO: push kept responses, pop on decode handshake, flush on redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else if (bus.redirect_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= bus.imem_rdata_i;
                r_fifo_pc[r_wr_ptr]    <= w_tag_head;
                r_wr_ptr               <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_queue
// Brief    : Randomised bench for ifetch_queue. An in-order memory model with
//            random grant/latency feeds the DUT; a queue-based reference of
//            the fetch rules predicts req/addr/valid/count and the accepted
//            instruction stream. Directed phases hit streaming, stall,
//            redirect, address wrap and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;
    localparam int          c_dw    = 32;
    localparam int          c_depth = 4;
    localparam int          c_maxo  = 2;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
    localparam int c_byp_lat = 0;
`else
    localparam int c_byp_lat = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_queue_if #(.DATA_WIDTH(c_dw), .DEPTH(c_depth)) bus ();

    ifetch_queue #(
        .DATA_WIDTH(c_dw), .DEPTH(c_depth), .MAX_OUTSTANDING(c_maxo), .RESET_PC(c_reset_pc)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    pend_t       pend[$];            // granted requests awaiting a response, in order
    int          cnt;                // words buffered for decode
    logic [31:0] next_pc;            // address of the next request
    logic [31:0] exp_pc;             // PC of the next instruction decode must see
    int          cyc, accepted;
    logic [31:0] last_acc_pc;
    int          last_acc_cyc, first_kept_cyc;
    bit          saw_addr0;
    int          n_checks, n_errors;

    int          gnt_pct, rv_pct, rdy_pct, lat_min, lat_max, redir_pm, spur_pct;
    bit          force_redir;
    logic [31:0] force_redir_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.instr_ready_i = 1'b0;
    endtask

    // Hold reset for n cycles, checking reset outputs, then release after a rising edge
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        drive_idle();
        repeat (n) begin
            @(negedge clk);
            check_eq("rst_req",   bus.imem_req_o,    1'b0);
            check_eq("rst_addr",  bus.imem_addr_o,   c_reset_pc);
            check_eq("rst_valid", bus.instr_valid_o, 1'b0);
            check_eq("rst_instr", bus.instr_o,       32'h0);
            check_eq("rst_pc",    bus.instr_pc_o,    32'h0);
            check_eq("rst_count", bus.fifo_count_o,  32'h0);
        end
        pend.delete();
        cnt     = 0;
        next_pc = c_reset_pc;
        exp_pc  = c_reset_pc;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive at posedge+1, check and update the model at negedge
    task automatic step();
        bit          rv_q, rv, redir, rdy, gnt, kept, m_req, m_valid, acc;
        logic [31:0] rpc;
        int          nstale;
        rv_q = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(0, 99) < rv_pct);
        rv   = rv_q || ((pend.size() == 0) && ($urandom_range(0, 99) < spur_pct));
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rv_q ? memf(pend[0].addr) : $urandom();
        redir = force_redir || ($urandom_range(0, 999) < redir_pm);
        rpc   = force_redir ? force_redir_pc : $urandom();
        force_redir = 1'b0;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = rpc;
        rdy = ($urandom_range(0, 99) < rdy_pct);
        gnt = ($urandom_range(0, 99) < gnt_pct);
        bus.instr_ready_i = rdy;
        bus.imem_gnt_i    = gnt;

        @(negedge clk);
        nstale = 0;
        foreach (pend[i]) if (pend[i].stale) nstale++;
        m_req = !redir && (cnt + pend.size() < c_depth) && (pend.size() < c_maxo) && (nstale == 0);
        check_eq("imem_req", bus.imem_req_o, m_req);
        if (m_req) check_eq("imem_addr", bus.imem_addr_o, next_pc);
        if (bus.imem_req_o && gnt && bus.imem_addr_o == 32'h0) saw_addr0 = 1'b1;
        kept = rv_q && !pend[0].stale && !redir;
`ifdef IFQ_BYPASS_EN
        m_valid = !redir && (cnt > 0 || (kept && rdy));
`else
        m_valid = !redir && (cnt > 0);
`endif
        check_eq("instr_valid", bus.instr_valid_o, m_valid);
        check_eq("fifo_count",  bus.fifo_count_o,  cnt);
        acc = m_valid && rdy;
        if (acc) begin
            check_eq("instr_pc", bus.instr_pc_o, exp_pc);
            check_eq("instr",    bus.instr_o,    memf(exp_pc));
            last_acc_pc  = exp_pc;
            last_acc_cyc = cyc;
            exp_pc       = exp_pc + 32'd4;
            accepted++;
        end
        if (kept && first_kept_cyc < 0) first_kept_cyc = cyc;

        if (rv_q) void'(pend.pop_front());
        if (kept) cnt++;
        if (acc)  cnt--;
        if (redir) begin
            cnt = 0;
            foreach (pend[i]) pend[i].stale = 1'b1;
            next_pc = {rpc[31:2], 2'b00};
            exp_pc  = next_pc;
        end
        if (m_req && gnt) begin
            pend.push_back('{addr: next_pc,
                             due: cyc + 1 + lat_min + $urandom_range(0, lat_max - lat_min),
                             stale: 1'b0});
            next_pc = next_pc + 32'd4;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Redirect now, then require the first accepted PC to be the aligned target
    task automatic redirect_and_expect(input string tag, input logic [31:0] raw,
                                       input logic [31:0] target);
        int acc0;
        bit got;
        force_redir    = 1'b1;
        force_redir_pc = raw;
        step();
        acc0 = accepted;
        got  = 1'b0;
        first_kept_cyc = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (accepted > acc0) got = 1'b1;
        end
        check_eq({tag, "_seen"}, got, 1'b1);
        check_eq({tag, "_pc"},   last_acc_pc, target);
        check_eq({tag, "_lat"},  last_acc_cyc - first_kept_cyc, c_byp_lat);
    endtask

    task automatic set_traffic(input int g, input int rv, input int rd, input int lmin,
                               input int lmax, input int rpm, input int sp);
        gnt_pct = g; rv_pct = rv; rdy_pct = rd; lat_min = lmin; lat_max = lmax;
        redir_pm = rpm; spur_pct = sp;
    endtask

    initial begin
        int  a0;
        bit  found;
        n_checks = 0; n_errors = 0; cyc = 0; accepted = 0;
        first_kept_cyc = -1; last_acc_cyc = 0; last_acc_pc = '0;
        force_redir = 1'b0; force_redir_pc = '0; saw_addr0 = 1'b0;
        set_traffic(100, 100, 100, 0, 0, 0, 0);
        do_reset(3);

        // Back-to-back streaming with single-cycle memory
        a0 = accepted;
        repeat (40) step();
        check_eq("stream_rate", (accepted - a0) >= 36, 1'b1);

        // Decode stalls: buffer fills, requests stop, then drains in order
        rdy_pct = 0;
        repeat (10) step();
        check_eq("stall_count", bus.fifo_count_o, c_depth);
        check_eq("stall_req",   bus.imem_req_o,   1'b0);
        rdy_pct = 100;
        repeat (10) step();

        // Redirect with two requests in flight and no response this cycle
        set_traffic(100, 100, 100, 3, 3, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pend.size() == 2 && pend[0].due > cyc) found = 1'b1;
            else step();
        end
        check_eq("redir2_setup", found, 1'b1);
        redirect_and_expect("redir_0x103", 32'h0000_0103, 32'h0000_0100);

        // Redirect coinciding with a response while decode is ready
        set_traffic(100, 100, 100, 1, 1, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pend.size() > 0 && pend[0].due <= cyc && cnt > 0) found = 1'b1;
            else step();
        end
        check_eq("redir_rv_setup", found, 1'b1);
        redirect_and_expect("redir_rv", 32'h0000_0200, 32'h0000_0200);

        // Fetch address wraps past the top of the address space
        set_traffic(100, 100, 100, 0, 0, 0, 0);
        saw_addr0 = 1'b0;
        redirect_and_expect("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFF8);
        repeat (10) step();
        check_eq("wrap_addr0", saw_addr0, 1'b1);

        // Reset in the middle of traffic, then stray responses must be ignored
        set_traffic(70, 70, 70, 0, 2, 0, 0);
        repeat (15) step();
        do_reset(2);
        set_traffic(80, 80, 80, 0, 2, 0, 30);
        repeat (30) step();

        // Randomised traffic with periodic traffic-profile changes and occasional resets
        a0 = accepted;
        for (int blk = 0; blk < 30; blk++) begin
            set_traffic($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100),
                        0, $urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 20));
            if (blk == 10 || blk == 20) do_reset(2);
            repeat (100) step();
        end
        check_eq("random_progress", accepted > a0 + 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch unit with prefetch buffer, directly upstream of the IF/ID pipeline register. Issues word-aligned requests to instruction memory over a req/gnt/rvalid interface, buffers returned words with their PCs in a DEPTH-entry FIFO, and presents them to decode through a valid/ready handshake. A redirect from the branch/jump resolution logic flushes the buffer, discards in-flight responses, and restarts fetch at the target.

## Interface
- DATA_WIDTH, 32, instruction and address width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests (≥1, ≤DEPTH)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- redirect_i  in  1  flush and restart fetch
- redirect_pc_i  in  DATA_WIDTH  restart target; bits [1:0] ignored (treated as 0)
- imem_req_o  out  1  request offer
- imem_addr_o  out  DATA_WIDTH  request address, always word-aligned
- imem_gnt_i  in  1  request accepted this cycle when imem_req_o=1
- imem_rvalid_i  in  1  response valid; responses return in request order
- imem_rdata_i  in  DATA_WIDTH  response instruction word
- instr_valid_o  out  1  instr_o/instr_pc_o valid
- instr_o  out  DATA_WIDTH  instruction at FIFO head
- instr_pc_o  out  DATA_WIDTH  PC of instr_o
- instr_ready_i  in  1  decode accepts head this cycle
- fifo_count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: fetch_pc, outstanding counter, discard counter, in-order PC tag queue (MAX_OUTSTANDING entries), data FIFO (instr, pc).
- Issue: imem_req_o = !redirect_i && (fifo_count + outstanding) < DEPTH && outstanding < MAX_OUTSTANDING && discard == 0. imem_addr_o = fetch_pc. imem_req_o/addr need not be held stable when not granted.
- req&gnt: outstanding+1, fetch_pc+4 (wraps modulo 2^DATA_WIDTH), tag queue pushes fetch_pc.
- rvalid with discard == 0: tag queue pop, outstanding−1, FIFO push {rdata, tag}. Slot reservation guarantees FIFO never overflows.
- rvalid with discard > 0: word dropped, discard−1, outstanding−1.
- rvalid with outstanding == 0: ignored, no state change.
- Pop: instr_valid_o && instr_ready_i.
- Redirect (cycle R): FIFO and tag queue cleared; fetch_pc ← {redirect_pc_i[31:2],2'b00}; discard ← outstanding minus (1 if rvalid in R); no grant possible in R; instr_valid_o forced 0 combinationally in R; any pop in R has no effect.
- Simultaneous push and pop: both take effect; count unchanged.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, fifo_count_o=0; outstanding=discard=0.
- First imem_req_o=1 in first cycle after rst_n deasserts.
- Response in cycle N (FIFO non-empty or bypass off) → instr_valid_o in N+1.
- Redirect in R → first request to target in R+1 if discard==0, else cycle after last discarded response.
- Reset asserted mid-operation: all state cleared immediately; responses arriving after release are treated as outstanding==0 and ignored (memory must be reset with core).
- Throughput: one instruction/cycle sustained with single-cycle memory and MAX_OUTSTANDING≥2.

## Configuration
- IFQ_BYPASS_EN defined: when FIFO empty, discard==0, no redirect, rvalid and instr_ready_i both high in cycle N, word passes combinationally to instr_o/instr_pc_o with instr_valid_o=1 in N and is not written to FIFO. If instr_ready_i=0, word is pushed as normal.
- Undefined: outputs driven only from FIFO head; minimum response-to-valid latency 1 cycle.

## Test plan
- Reset release, gnt always 1, rvalid 1 cycle after gnt, ready=1 → PCs 0x0,0x4,0x8… emerge one per cycle, instr matches memory image.
- instr_ready_i=0 for 10 cycles → fifo_count_o saturates at 4, imem_req_o low, no data lost; ready=1 → words drain in order.
- Redirect to 0x103 with 2 outstanding → both responses dropped, next imem_addr_o=0x100, first instr_pc_o=0x100.
- Redirect same cycle as rvalid and instr_ready_i=1 → instr_valid_o=0 in that cycle, response dropped, discard=outstanding−1.
- fetch_pc=0xFFFF_FFFC → next request address 0x0000_0000.
- IFQ_BYPASS_EN defined, empty FIFO, rvalid with ready=1 → instr_valid_o same cycle, fifo_count_o stays 0; undefined → valid one cycle later.
